// File: rtl/mtm_alu_deserializer.sv
// mtm_alu_deserializer: serial frame receiver feeding the ALU core.
// Frames are 11 bits, MSB first: start(0), type, 8 payload bits, stop(1).
// Data frames shift operand bytes in (B first, then A); a command frame
// produces a one-cycle out_valid strobe with operands or an error code.
// Optional feature macro: MTM_ALU_CRC_CHECK_EN (enables the CRC4 check).
module mtm_alu_deserializer #(
  parameter int N_DATA = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [2:0]  OP,
  output logic [2:0]  err,
  output logic        out_valid
);

  localparam int CW = $clog2(N_DATA + 2);

  typedef enum logic [1:0] {IDLE, TYPE, PAYLOAD, STOP} state_t;

  state_t          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic            is_cmd_q;
  logic [7:0]      pay_q;
  logic [63:0]     sr_q;
  logic [CW-1:0]   count_q;
  logic            frame_bad_q;
  logic [31:0]     a_q, b_q;
  logic [2:0]      op_q, err_q;
  logic            vld_q;

  logic [2:0]      op_w;
  logic            op_ok, crc_bad, data_err;
  logic [2:0]      err_d;

  assign op_w = pay_q[6:4];

`ifdef MTM_ALU_CRC_CHECK_EN
  // CRC4, poly x^4+x+1, init 0, MSB first, no reflection/final XOR
  function automatic logic [3:0] crc4(input logic [67:0] msg);
    logic [3:0] c;
    logic       fb;
    c = 4'b0000;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ msg[i];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    end
    return c;
  endfunction

  // compare received CRC field against the operands and opcode
  always_comb begin
    crc_bad = (crc4({sr_q, 1'b1, op_w}) != pay_q[3:0]);
  end
`else
  // CRC field is ignored in this build
  always_comb begin
    crc_bad = 1'b0;
  end
`endif

  // opcode legality and prioritized error code for the command in STOP
  always_comb begin
    op_ok    = (op_w == 3'b000) || (op_w == 3'b001) ||
               (op_w == 3'b100) || (op_w == 3'b101);
    data_err = (count_q != CW'(N_DATA)) || frame_bad_q || !sin;
    err_d    = 3'b000;
    if (data_err)     err_d = 3'b100;
    else if (crc_bad) err_d = 3'b010;
    else if (!op_ok)  err_d = 3'b001;
  end

  // frame sequencing: next state and payload bit counter
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE:    if (!sin) state_d = TYPE;
      TYPE:    begin
        state_d   = PAYLOAD;
        bit_cnt_d = 3'd0;
      end
      PAYLOAD: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = STOP;
      end
      STOP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // frame capture, operand assembly and result strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_cmd_q    <= 1'b0;
      pay_q       <= 8'h00;
      sr_q        <= 64'h0;
      count_q     <= '0;
      frame_bad_q <= 1'b0;
      a_q         <= 32'h0;
      b_q         <= 32'h0;
      op_q        <= 3'b000;
      err_q       <= 3'b000;
      vld_q       <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      case (state_q)
        TYPE:    is_cmd_q <= sin;
        PAYLOAD: pay_q    <= {pay_q[6:0], sin};
        STOP: begin
          if (is_cmd_q) begin
            // operands are loaded even on error; consumers ignore them then
            vld_q       <= 1'b1;
            b_q         <= sr_q[63:32];
            a_q         <= sr_q[31:0];
            op_q        <= op_w;
            err_q       <= err_d;
            count_q     <= '0;
            frame_bad_q <= 1'b0;
          end else if (sin) begin
            sr_q <= {sr_q[55:0], pay_q};
            if (count_q != CW'(N_DATA + 1)) count_q <= count_q + 1'b1;
          end else begin
            frame_bad_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign OP        = op_q;
  assign err       = err_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Directed bench for mtm_alu_deserializer; frames are driven on the falling
// edge and outputs sampled on the falling edge after the sampling posedge.
module tb_mtm_alu_deserializer;

  logic        clk;
  logic        rst_n;
  logic        sin;
  logic [31:0] A, B;
  logic [2:0]  OP, err;
  logic        out_valid;

  int n_chk  = 0;
  int n_fail = 0;
  int strobes = 0;
  int exp_strobes = 0;

  mtm_alu_deserializer #(.N_DATA(8)) dut (
    .clk(clk), .rst_n(rst_n), .sin(sin),
    .A(A), .B(B), .OP(OP), .err(err), .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && out_valid) strobes++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // CRC4 via polynomial long division of {msg, 4'b0} by x^4+x+1
  function automatic logic [3:0] crc_model(input logic [31:0] b, input logic [31:0] a,
                                           input logic [2:0] op);
    logic [71:0] m;
    m = {b, a, 1'b1, op, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
    return m[3:0];
  endfunction

  task automatic send_bit(input logic b);
    @(negedge clk);
    sin = b;
  endtask

  task automatic send_frame(input logic typ, input logic [7:0] pay, input logic stop);
    send_bit(1'b0);
    send_bit(typ);
    for (int i = 7; i >= 0; i--) send_bit(pay[i]);
    send_bit(stop);
  endtask

  task automatic send_data(input logic [63:0] bytes8, input int n);
    for (int i = 0; i < n; i++) send_frame(1'b0, bytes8[63 - 8*i -: 8], 1'b1);
  endtask

  task automatic send_cmd(input string tag, input logic [2:0] op, input logic [3:0] crc,
                          input logic stop, input logic [2:0] exp_err,
                          input logic [31:0] exp_b, input logic [31:0] exp_a);
    send_frame(1'b1, {1'b0, op, crc}, stop);
    exp_strobes++;
    @(negedge clk);
    sin = 1'b1;
    chk({tag, ".vld"}, 64'(out_valid), 64'd1);
    chk({tag, ".err"}, 64'(err), 64'(exp_err));
    if (exp_err == 3'b000) begin
      chk({tag, ".B"},  64'(B),  64'(exp_b));
      chk({tag, ".A"},  64'(A),  64'(exp_a));
      chk({tag, ".OP"}, 64'(OP), 64'(op));
    end
    @(negedge clk);
    chk({tag, ".vld_drop"}, 64'(out_valid), 64'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] crc_err;
`ifdef MTM_ALU_CRC_CHECK_EN
    crc_err = 3'b010;
`else
    crc_err = 3'b000;
`endif
    sin   = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.A",   64'(A),   64'd0);
    chk("rst.B",   64'(B),   64'd0);
    chk("rst.OP",  64'(OP),  64'd0);
    chk("rst.err", 64'(err), 64'd0);
    chk("rst.vld", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // happy path: zero operands, OP=AND, CRC=1011
    send_data(64'h0, 8);
    send_cmd("happy", 3'b000, 4'hB, 1'b1, 3'b000, 32'h0, 32'h0);

    // operand order with model CRC
    send_data(64'h11223344_55667788, 8);
    send_cmd("order", 3'b100, crc_model(32'h11223344, 32'h55667788, 3'b100), 1'b1,
             3'b000, 32'h11223344, 32'h55667788);

    // short packet count, then clean sequence proves count cleared
    send_data(64'h0, 7);
    send_cmd("cnt7", 3'b000, 4'hB, 1'b1, 3'b100, 32'h0, 32'h0);
    send_data(64'hA1B2C3D4_0F1E2D3C, 8);
    send_cmd("cnt8", 3'b101, crc_model(32'hA1B2C3D4, 32'h0F1E2D3C, 3'b101), 1'b1,
             3'b000, 32'hA1B2C3D4, 32'h0F1E2D3C);

    // too many data frames
    send_data(64'h0, 8);
    send_data(64'h0, 1);
    send_cmd("cnt9", 3'b000, 4'hB, 1'b1, 3'b100, 32'h0, 32'h0);

    // CRC mismatch
    send_data(64'h0, 8);
    send_cmd("crc", 3'b000, 4'hA, 1'b1, crc_err, 32'h0, 32'h0);

    // illegal opcode with correct CRC
    send_data(64'h0, 8);
    send_cmd("badop", 3'b010, crc_model(32'h0, 32'h0, 3'b010), 1'b1, 3'b001, 32'h0, 32'h0);

    // data frame with bad stop bit among eight good ones
    send_data(64'h0, 3);
    send_frame(1'b0, 8'h5A, 1'b0);
    send_data(64'h0, 5);
    send_cmd("dstop", 3'b000, 4'hB, 1'b1, 3'b100, 32'h0, 32'h0);
    send_data(64'h0, 8);
    send_cmd("dstop_clr", 3'b001, crc_model(32'h0, 32'h0, 3'b001), 1'b1,
             3'b000, 32'h0, 32'h0);

    // command with bad stop bit
    send_data(64'h0, 8);
    send_cmd("cstop", 3'b000, 4'hB, 1'b0, 3'b100, 32'h0, 32'h0);

    // reset mid-payload of a data frame after 4 good frames
    send_data(64'hFFFFFFFF_FFFFFFFF, 4);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid.A",   64'(A),   64'd0);
    chk("mid.B",   64'(B),   64'd0);
    chk("mid.OP",  64'(OP),  64'd0);
    chk("mid.err", 64'(err), 64'd0);
    chk("mid.vld", 64'(out_valid), 64'd0);
    @(negedge clk);
    sin   = 1'b1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid.nostrobe", 64'(out_valid), 64'd0);
    send_data(64'h01020304_05060708, 8);
    send_cmd("post_rst", 3'b100, crc_model(32'h01020304, 32'h05060708, 3'b100), 1'b1,
             3'b000, 32'h01020304, 32'h05060708);

    repeat (2) @(negedge clk);
    chk("strobes", 64'(strobes), 64'(exp_strobes));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
